data_memory_port: RTL and testbench

Responder end of the HC4 data-address path: accepts one memory request at a time from the core, using the 8-bit address produced by the core's address selection logic, and performs the access. The access targets a 256 x 4-bit data RAM.
- Register/immediate modes present 0x00–0x0F.
- [AB] mode presents the full 0x00–0xFF.

Writes complete on acceptance. Reads return data through a response channel with backpressure. The block sits between the core's load/store unit and the data RAM array, which is internal to this block.

---
 rtl/data_memory_port_if.sv | 25 ++
 rtl/data_memory_port.sv | 118 +++++++++++
 tb/tb_data_memory_port.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_port_if.sv
// Request/response bundle between the core's load/store unit (master)
// and the data memory port (slave).
interface data_memory_port_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/data_memory_port.sv
// Single-outstanding data RAM port for the HC4 core: zero-latency writes, registered
// reads with a backpressured response. Define HC4_MEM_CLEAR_EN to zero the RAM after reset.
module data_memory_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  data_memory_port_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef HC4_MEM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, RESP} state_t;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_reg;
  logic                  req_ready_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  logic                  accept;
  logic                  accept_write;
  logic                  accept_read;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef HC4_MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clear_cnt_reg;
`endif

  // req_ready_reg is only high in IDLE, so it doubles as the state qualifier.
  assign accept       = bus.req_valid & req_ready_reg & ~rst;
  assign accept_write = accept & bus.req_write;
  assign accept_read  = accept & ~bus.req_write;

  always_comb begin
    mem_we    = accept_write;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_wdata;
`ifdef HC4_MEM_CLEAR_EN
    if (state_reg == CLEAR && !rst) begin
      mem_we    = 1'b1;
      mem_waddr = clear_cnt_reg;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read register keeps the last value after the response is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_reg <= '0;
    end else if (accept_read) begin
      rsp_data_reg <= mem[bus.req_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef HC4_MEM_CLEAR_EN
      state_reg     <= CLEAR;
      req_ready_reg <= 1'b0;
      clear_cnt_reg <= '0;
`else
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
`endif
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept_read) begin
            state_reg     <= RESP;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
          end
        end
`ifdef HC4_MEM_CLEAR_EN
        CLEAR: begin
          clear_cnt_reg <= clear_cnt_reg + ADDR_WIDTH'(1);
          if (clear_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
endmodule

// File: tb/tb_data_memory_port.sv
// Directed bench for data_memory_port: expected read data is queued when a read is
// issued and popped when the response appears. Covers HC4_MEM_CLEAR_EN when defined.
module tb_data_memory_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] exp_q [$];

  data_memory_port_if bus ();

  data_memory_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [3:0] data);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    check("wr_ready", 8'(bus.req_ready), 8'h1);
    tick();
    bus.req_valid = 1'b0;
    $display("write addr=%h data=%h", addr, data);
  endtask

  // Issue a read; expected data goes to the scoreboard.
  task automatic issue_read(input logic [7:0] addr, input logic [3:0] exp);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    check("rd_ready", 8'(bus.req_ready), 8'h1);
    exp_q.push_back(exp);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Bounded wait for rsp_valid; the response must be there right after acceptance.
  task automatic wait_rsp();
    int lat = 0;
    while (!bus.rsp_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("rd_latency", 8'(lat), 8'h0);
  endtask

  task automatic consume_rsp(input logic [7:0] addr);
    logic [3:0] exp;
    if (exp_q.size() == 0) begin
      check("sb_empty", 8'h1, 8'h0);
      exp = 4'h0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("rd_valid", 8'(bus.rsp_valid), 8'h1);
    check("rd_data", 8'(bus.rsp_data), 8'(exp));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rd_done_valid", 8'(bus.rsp_valid), 8'h0);
    check("rd_done_ready", 8'(bus.req_ready), 8'h1);
    check("rd_hold_data", 8'(bus.rsp_data), 8'(exp));
    $display("read  addr=%h data=%h expected=%h", addr, bus.rsp_data, exp);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [3:0] exp);
    issue_read(addr, exp);
    wait_rsp();
    consume_rsp(addr);
  endtask

`ifdef HC4_MEM_CLEAR_EN
  task automatic count_clear(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 600) begin
      check("clr_valid", 8'(bus.rsp_valid), 8'h0);
      tick();
      n++;
    end
    check(tag, n[7:0], 8'h00);
    check({tag, "_hi"}, 8'(n >> 8), 8'h01);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    tick();
    tick();
    check("rst_rsp_valid", 8'(bus.rsp_valid), 8'h0);
    check("rst_rsp_data", 8'(bus.rsp_data), 8'h0);
`ifdef HC4_MEM_CLEAR_EN
    check("rst_req_ready", 8'(bus.req_ready), 8'h0);
    rst = 1'b0;
    count_clear("clr_cycles");
`else
    check("rst_req_ready", 8'(bus.req_ready), 8'h1);
    rst = 1'b0;
    tick();
    check("first_ready", 8'(bus.req_ready), 8'h1);
`endif

    // Write then read on the next cycle.
    do_write(8'hAB, 4'h5);
    do_read(8'hAB, 4'h5);

    // Register window versus full range.
    do_write(8'h00, 4'h6);
    do_write(8'h05, 4'hA);
    do_write(8'hFF, 4'h3);
    do_read(8'h05, 4'hA);
    do_read(8'hFF, 4'h3);
    do_read(8'h00, 4'h6);

    // Backpressure with an intruding write during RESP.
    issue_read(8'hAB, 4'h5);
    wait_rsp();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'hAB;
    bus.req_wdata = 4'hC;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 8'(bus.rsp_valid), 8'h1);
      check("bp_ready", 8'(bus.req_ready), 8'h0);
      check("bp_data", 8'(bus.rsp_data), 8'h5);
      tick();
    end
    // Write still presented in the consuming cycle; it must be ignored.
    consume_rsp(8'hAB);
    bus.req_valid = 1'b0;
    do_read(8'hAB, 4'h5);

    // Back-to-back writes.
    for (int i = 0; i < 4; i++) begin
      do_write(8'(8'h10 + i), 4'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      do_read(8'(8'h10 + i), 4'(i + 1));
    end

    // Reset while a response is pending.
    issue_read(8'hFF, 4'h3);
    wait_rsp();
    rst = 1'b1;
    tick();
    void'(exp_q.pop_front());
    check("rstr_valid", 8'(bus.rsp_valid), 8'h0);
    check("rstr_data", 8'(bus.rsp_data), 8'h0);
    rst = 1'b0;
    $display("reset during RESP");
`ifdef HC4_MEM_CLEAR_EN
    count_clear("clr_after_resp");
    do_read(8'h05, 4'h0);

    do_write(8'h37, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("clr_mid_ready", 8'(bus.req_ready), 8'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear("clr_restart");
    do_read(8'h37, 4'h0);
`else
    do_read(8'h05, 4'hA);
    do_read(8'h13, 4'h4);
`endif

    check("sb_drained", 8'(exp_q.size()), 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
